// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Writeback arbiter between the functional units and the common data bus.
// Each of NUM_REQ result sources (0 = ALU, 1 = branch, 2 = LSU, 3 = LSQ) owns a
// one-entry holding slot. Every cycle the NUM_PORTS oldest held results (by ROB
// age relative to rob_head) are broadcast, oldest on port 0. Results younger
// than a mispredicted branch are squashed.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   req_valid/req_ready  per-source handshake into the holding slots
//   req_preg/req_rob_tag/req_data  per-source result payload
//   rob_head             tag of the oldest ROB entry (age reference)
//   mispredict/_tag      flush request and tag of the mispredicted branch
//   cdb_valid/preg/rob_tag/data    NUM_PORTS broadcast ports (combinational)
//   grant_cnt            number of ports broadcasting this cycle
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 3,
  parameter int TAG_W     = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][6:0]             req_preg,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_rob_tag,
  input  logic [NUM_REQ-1:0][31:0]            req_data,
  input  logic [TAG_W-1:0]                    rob_head,
  input  logic                                mispredict,
  input  logic [TAG_W-1:0]                    mispredict_tag,
  output logic [NUM_PORTS-1:0]                cdb_valid,
  output logic [NUM_PORTS-1:0][6:0]           cdb_preg,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]     cdb_rob_tag,
  output logic [NUM_PORTS-1:0][31:0]          cdb_data,
  output logic [1:0]                          grant_cnt
);

  // Rank width must hold any count of older candidates and the port count.
  localparam int MAXN = (NUM_REQ > NUM_PORTS) ? NUM_REQ : NUM_PORTS;
  localparam int RW   = $clog2(MAXN + 1);

  logic [NUM_REQ-1:0]              slotV_q,    slotV_d;
  logic [NUM_REQ-1:0][6:0]         slotPreg_q, slotPreg_d;
  logic [NUM_REQ-1:0][TAG_W-1:0]   slotTag_q,  slotTag_d;
  logic [NUM_REQ-1:0][31:0]        slotData_q, slotData_d;

  logic [NUM_REQ-1:0][TAG_W-1:0]   slotAge;
  logic [NUM_REQ-1:0][TAG_W-1:0]   reqAge;
  logic [TAG_W-1:0]                mpAge;
  logic [NUM_REQ-1:0]              slotSquash;
  logic [NUM_REQ-1:0]              reqSquash;
  logic [NUM_REQ-1:0]              cand;
  logic [NUM_REQ-1:0][RW-1:0]      rank;
  logic [NUM_REQ-1:0]              grant;

  // Ages are modular distances from the ROB head, so the unsigned subtraction
  // handles wrap-around for free. A slot younger than the mispredicted branch
  // is squashed; the branch itself and anything older stays eligible.
  always_comb begin
    mpAge      = mispredict_tag - rob_head;
    slotAge    = '0;
    reqAge     = '0;
    slotSquash = '0;
    reqSquash  = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slotAge[i]    = slotTag_q[i] - rob_head;
      reqAge[i]     = req_rob_tag[i] - rob_head;
      slotSquash[i] = mispredict && (slotAge[i] > mpAge);
      reqSquash[i]  = mispredict && (reqAge[i] > mpAge);
      cand[i]       = slotV_q[i] && !slotSquash[i];
    end
  end

  // Each candidate's rank is the number of candidates strictly ahead of it
  // (older, or equal age with a lower source index). Ranks are therefore
  // unique and the rank doubles as the port number for the winners.
  always_comb begin
    rank  = '0;
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && cand[j] &&
            ((slotAge[j] < slotAge[i]) || (slotAge[j] == slotAge[i] && j < i))) begin
          rank[i] = rank[i] + RW'(1);
        end
      end
      grant[i] = cand[i] && (rank[i] < RW'(NUM_PORTS));
    end
  end

  // Broadcast ports are a one-hot mux of the granted slots. Everything is
  // forced idle while reset is low so a held result never leaks onto the bus.
  always_comb begin
    cdb_valid   = '0;
    cdb_preg    = '0;
    cdb_rob_tag = '0;
    cdb_data    = '0;
    grant_cnt   = '0;
    req_ready   = '1;
    if (reset) begin
      req_ready = ~slotV_q | grant;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i] && rank[i] == RW'(p)) begin
            cdb_valid[p]   = 1'b1;
            cdb_preg[p]    = slotPreg_q[i];
            cdb_rob_tag[p] = slotTag_q[i];
            cdb_data[p]    = slotData_q[i];
          end
        end
        if (cdb_valid[p]) grant_cnt = grant_cnt + 2'd1;
      end
    end
  end

  // Slot update: granted or squashed slots empty out, and a handshake in the
  // same cycle refills them. An incoming result that is already younger than
  // the mispredict is accepted but never becomes valid.
  always_comb begin
    slotV_d    = slotV_q;
    slotPreg_d = slotPreg_q;
    slotTag_d  = slotTag_q;
    slotData_d = slotData_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] || slotSquash[i]) slotV_d[i] = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        slotV_d[i]    = !reqSquash[i];
        slotPreg_d[i] = req_preg[i];
        slotTag_d[i]  = req_rob_tag[i];
        slotData_d[i] = req_data[i];
      end
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slotV_q    <= '0;
      slotPreg_q <= '0;
      slotTag_q  <= '0;
      slotData_q <= '0;
    end else begin
      slotV_q    <= slotV_d;
      slotPreg_q <= slotPreg_d;
      slotTag_q  <= slotTag_d;
      slotData_q <= slotData_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed scenarios with hand-computed
// expectations, then randomized traffic checked against a behavioural model
// that sorts held results by ROB age each cycle.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int NP = 3;
  localparam int TW = 5;

  logic                     clk;
  logic                     reset;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][6:0]       req_preg;
  logic [NR-1:0][TW-1:0]    req_rob_tag;
  logic [NR-1:0][31:0]      req_data;
  logic [TW-1:0]            rob_head;
  logic                     mispredict;
  logic [TW-1:0]            mispredict_tag;
  logic [NP-1:0]            cdb_valid;
  logic [NP-1:0][6:0]       cdb_preg;
  logic [NP-1:0][TW-1:0]    cdb_rob_tag;
  logic [NP-1:0][31:0]      cdb_data;
  logic [1:0]               grant_cnt;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: one entry per source.
  logic                     mV[NR];
  logic [6:0]               mPreg[NR];
  logic [TW-1:0]            mTag[NR];
  logic [31:0]              mData[NR];
  logic [NP-1:0]            eValid;
  logic [NP-1:0][6:0]       ePreg;
  logic [NP-1:0][TW-1:0]    eTag;
  logic [NP-1:0][31:0]      eData;
  logic [NR-1:0]            eGrant;
  logic [NR-1:0]            eReady;
  logic [1:0]               eCnt;
  logic                     srcPending[NR];

  cdb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .TAG_W(TW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_preg       (req_preg),
    .req_rob_tag    (req_rob_tag),
    .req_data       (req_data),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .cdb_valid      (cdb_valid),
    .cdb_preg       (cdb_preg),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_data       (cdb_data),
    .grant_cnt      (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h required %0h", name, observed, expected);
    end
  endtask

  // Drive one source's request lines.
  task automatic applyStimulus(input int i, input logic v, input logic [6:0] p,
                               input logic [TW-1:0] t, input logic [31:0] d);
    req_valid[i]   = v;
    req_preg[i]    = p;
    req_rob_tag[i] = t;
    req_data[i]    = d;
  endtask

  function automatic int ageOf(input logic [TW-1:0] t);
    return (int'(t) - int'(rob_head) + (1 << TW)) % (1 << TW);
  endfunction

  function automatic logic isYounger(input logic [TW-1:0] t);
    return mispredict && (ageOf(t) > ageOf(mispredict_tag));
  endfunction

  // Expected outputs: repeatedly pick the oldest eligible held result.
  task automatic modelOutputs();
    bit taken[NR];
    int best;
    eValid = '0; ePreg = '0; eTag = '0; eData = '0;
    eGrant = '0; eReady = '1; eCnt = '0;
    for (int i = 0; i < NR; i++) taken[i] = 1'b0;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        best = -1;
        for (int i = 0; i < NR; i++) begin
          if (mV[i] && !taken[i] && !isYounger(mTag[i]) &&
              (best < 0 || ageOf(mTag[i]) < ageOf(mTag[best]))) best = i;
        end
        if (best >= 0) begin
          taken[best] = 1'b1;
          eGrant[best] = 1'b1;
          eValid[p] = 1'b1;
          ePreg[p]  = mPreg[best];
          eTag[p]   = mTag[best];
          eData[p]  = mData[best];
          eCnt      = eCnt + 2'd1;
        end
      end
      for (int i = 0; i < NR; i++) eReady[i] = !mV[i] || eGrant[i];
    end
  endtask

  // Edge behaviour of the model, evaluated with the inputs of the ending cycle.
  task automatic modelUpdate();
    logic hs;
    for (int i = 0; i < NR; i++) begin
      hs = reset && req_valid[i] && eReady[i];
      if (!reset) begin
        mV[i] = 1'b0;
      end else begin
        if (eGrant[i] || isYounger(mTag[i])) mV[i] = 1'b0;
        if (hs) begin
          mV[i]    = !isYounger(req_rob_tag[i]);
          mPreg[i] = req_preg[i];
          mTag[i]  = req_rob_tag[i];
          mData[i] = req_data[i];
        end
      end
      srcPending[i] = req_valid[i] && !hs;
    end
  endtask

  initial begin
    reset = 1'b0;
    rob_head = '0;
    mispredict = 1'b0;
    mispredict_tag = '0;
    for (int i = 0; i < NR; i++) begin
      applyStimulus(i, 1'b1, 7'(i + 1), TW'(i), 32'h1000 + i);
      mV[i] = 1'b0;
      srcPending[i] = 1'b0;
    end

    // Reset held for two edges with every source requesting.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_cdb_valid", cdb_valid, 3'b000);
    checkOutput("reset_ready", req_ready, 4'b1111);
    reset = 1'b1;
    req_valid = '0;
    #1;
    checkOutput("post_reset_cdb_valid", cdb_valid, 3'b000);
    checkOutput("post_reset_ready", req_ready, 4'b1111);
    checkOutput("post_reset_grant_cnt", grant_cnt, 2'd0);
    checkOutput("post_reset_data", cdb_data, 96'h0);

    // Contention: four results, three ports.
    @(negedge clk);
    rob_head = 5'd0;
    applyStimulus(0, 1'b1, 7'd10, 5'd7, 32'hA000);
    applyStimulus(1, 1'b1, 7'd11, 5'd2, 32'hA001);
    applyStimulus(2, 1'b1, 7'd12, 5'd9, 32'hA002);
    applyStimulus(3, 1'b1, 7'd13, 5'd4, 32'hA003);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("cont_valid", cdb_valid, 3'b111);
    checkOutput("cont_tags", cdb_rob_tag, {5'd7, 5'd4, 5'd2});
    checkOutput("cont_preg", cdb_preg, {7'd10, 7'd13, 7'd11});
    checkOutput("cont_data", cdb_data, {32'hA000, 32'hA003, 32'hA001});
    checkOutput("cont_grant_cnt", grant_cnt, 2'd3);
    checkOutput("cont_ready", req_ready, 4'b1011);
    @(negedge clk); #1;
    checkOutput("cont2_valid", cdb_valid, 3'b001);
    checkOutput("cont2_tag", cdb_rob_tag, {5'd0, 5'd0, 5'd9});
    checkOutput("cont2_grant_cnt", grant_cnt, 2'd1);
    @(negedge clk); #1;
    checkOutput("cont3_valid", cdb_valid, 3'b000);

    // Wrap-around: head 30, tag 31 is older than tag 1.
    rob_head = 5'd30;
    applyStimulus(0, 1'b1, 7'd5, 5'd1, 32'hC001);
    applyStimulus(1, 1'b1, 7'd6, 5'd31, 32'hC031);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("wrap_valid", cdb_valid, 3'b011);
    checkOutput("wrap_tags", cdb_rob_tag, {5'd0, 5'd1, 5'd31});

    // Squash: slots 3, 5, 8 held, mispredict on 5, incoming 6 dropped.
    @(negedge clk);
    rob_head = 5'd0;
    applyStimulus(0, 1'b1, 7'd1, 5'd3, 32'hD003);
    applyStimulus(1, 1'b1, 7'd2, 5'd5, 32'hD005);
    applyStimulus(2, 1'b1, 7'd3, 5'd8, 32'hD008);
    @(negedge clk);
    req_valid = '0;
    mispredict = 1'b1;
    mispredict_tag = 5'd5;
    applyStimulus(3, 1'b1, 7'd4, 5'd6, 32'hD006);
    #1;
    checkOutput("squash_valid", cdb_valid, 3'b011);
    checkOutput("squash_tags", cdb_rob_tag, {5'd0, 5'd5, 5'd3});
    checkOutput("squash_ready", req_ready, 4'b1011);
    checkOutput("squash_grant_cnt", grant_cnt, 2'd2);
    @(negedge clk);
    mispredict = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("squash_after_valid", cdb_valid, 3'b000);
    checkOutput("squash_after_ready", req_ready, 4'b1111);

    // Back-to-back streaming from the ALU.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) applyStimulus(0, 1'b1, 7'(20 + k), TW'(k), 32'hB000 + k);
      else req_valid = '0;
      #1;
      checkOutput("stream_ready", req_ready, 4'b1111);
      if (k > 0) begin
        checkOutput("stream_valid", cdb_valid, 3'b001);
        checkOutput("stream_tag", cdb_rob_tag, 15'(k - 1));
        checkOutput("stream_preg", cdb_preg, 21'(20 + k - 1));
        checkOutput("stream_data", cdb_data, 96'(32'hB000 + k - 1));
      end
    end

    // Zero destination register is still broadcast.
    @(negedge clk);
    applyStimulus(0, 1'b1, 7'd0, 5'd4, 32'hE004);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("zero_valid", cdb_valid, 3'b001);
    checkOutput("zero_preg", cdb_preg, 21'd0);
    checkOutput("zero_tag", cdb_rob_tag, 15'd4);
    @(negedge clk); #1;
    checkOutput("zero_after_valid", cdb_valid, 3'b000);

    // Randomized traffic against the model (arbiter is empty here).
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) != 0);
      rob_head = TW'($urandom);
      mispredict = ($urandom_range(0, 5) == 0);
      mispredict_tag = TW'($urandom);
      for (int i = 0; i < NR; i++) begin
        if (!srcPending[i])
          applyStimulus(i, ($urandom_range(0, 9) < 6), 7'($urandom), TW'($urandom), $urandom);
      end
      #1;
      modelOutputs();
      checkOutput("rnd_valid", cdb_valid, eValid);
      checkOutput("rnd_preg", cdb_preg, ePreg);
      checkOutput("rnd_tag", cdb_rob_tag, eTag);
      checkOutput("rnd_data", cdb_data, eData);
      checkOutput("rnd_grant_cnt", grant_cnt, eCnt);
      checkOutput("rnd_ready", req_ready, eReady);
      @(posedge clk);
      modelUpdate();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
